// File: rtl/gcd_req_arbiter_if.sv
// Handshake bundle between the GCD request arbiter, its requesters and the shared GCD unit.
interface gcd_req_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 16
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   rsp_valid;
   logic [W-1:0]       rsp_result;
   logic               rsp_err;
   logic [N_REQ-1:0]   rsp_taken;
   logic               gcd_input_available;
   logic               gcd_input_ready;
   logic [W-1:0]       gcd_a;
   logic [W-1:0]       gcd_b;
   logic               gcd_result_rdy;
   logic [W-1:0]       gcd_result;
   logic               gcd_result_taken;

   // Arbiter view
   modport slave (
      input  req_valid, req_a, req_b, rsp_taken,
             gcd_input_available, gcd_result_rdy, gcd_result,
      output req_ready, rsp_valid, rsp_result, rsp_err,
             gcd_input_ready, gcd_a, gcd_b, gcd_result_taken
   );

   // Environment view: requesters plus the GCD unit
   modport master (
      output req_valid, req_a, req_b, rsp_taken,
             gcd_input_available, gcd_result_rdy, gcd_result,
      input  req_ready, rsp_valid, rsp_result, rsp_err,
             gcd_input_ready, gcd_a, gcd_b, gcd_result_taken
   );
endinterface

// File: rtl/gcd_req_arbiter.sv
// Round-robin arbiter sharing one GCD unit among N_REQ requesters; trivial operands
// bypass the unit and a stuck unit is aborted after TIMEOUT wait cycles.
module gcd_req_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   gcd_req_arbiter_if.slave bus,
   output logic [15:0]      served_cnt
);
   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   grant_q, last_grant_q;
   logic [W-1:0]       a_q, b_q, result_q;
   logic               err_q, in_rdy_q, taken_q;
   logic [N_REQ-1:0]   rsp_valid_q;
   logic [CNT_W-1:0]   wait_q;
   logic [15:0]        served_q;

   logic               grant_vld_c;
   logic [IDX_W-1:0]   grant_idx_c;
   logic [W-1:0]       a_sel_c, b_sel_c;
   logic               bypass_c;
   logic               accept_c, issue_c, done_c, abort_c, release_c;
   logic [W-1:0]       a_arr [N_REQ];
   logic [W-1:0]       b_arr [N_REQ];

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (idx == IDX_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] last, input int unsigned k);
      return IDX_W'((32'(last) + k) % N_REQ);
   endfunction

   for (genvar i = 0; i < int'(N_REQ); i++) begin : g_slice
      assign a_arr[i] = bus.req_a[i*W +: W];
      assign b_arr[i] = bus.req_b[i*W +: W];
   end

   // Round-robin pick: scan farthest-first so the nearest requester after last_grant wins
   always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      for (int unsigned k = N_REQ; k >= 1; k--) begin
         if (bus.req_valid[rr_idx(last_grant_q, k)]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = rr_idx(last_grant_q, k);
         end
      end
   end

   assign a_sel_c  = a_arr[grant_idx_c];
   assign b_sel_c  = b_arr[grant_idx_c];
   assign bypass_c = (a_sel_c == '0) || (b_sel_c == '0);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      accept_c  = 1'b0;
      issue_c   = 1'b0;
      done_c    = 1'b0;
      abort_c   = 1'b0;
      release_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_vld_c) begin
               accept_c = 1'b1;
               state_d  = bypass_c ? RETURN : ISSUE;
            end
         end
         ISSUE: begin
            if (bus.gcd_input_available) begin
               issue_c = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.gcd_result_rdy) begin
               done_c  = 1'b1;
               state_d = RETURN;
            end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
               abort_c = 1'b1;
               state_d = RETURN;
            end
         end
         RETURN: begin
            if (|(bus.rsp_taken & rsp_valid_q)) begin
               release_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant, operand, result and bookkeeping registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         grant_q      <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         in_rdy_q     <= 1'b0;
         taken_q      <= 1'b0;
         rsp_valid_q  <= '0;
         wait_q       <= '0;
         served_q     <= '0;
      end else begin
         taken_q <= done_c;
         if (state_q == WAIT) wait_q <= wait_q + CNT_W'(1);
         if (accept_c) begin
            grant_q <= grant_idx_c;
            a_q     <= a_sel_c;
            b_q     <= b_sel_c;
            if (bypass_c) begin
               result_q    <= (b_sel_c == '0) ? a_sel_c : b_sel_c;
               err_q       <= 1'b0;
               rsp_valid_q <= onehot(grant_idx_c);
            end else begin
               in_rdy_q <= 1'b1;
            end
         end
         if (issue_c) begin
            in_rdy_q <= 1'b0;
            wait_q   <= '0;
         end
         if (done_c) begin
            result_q    <= bus.gcd_result;
            err_q       <= 1'b0;
            rsp_valid_q <= onehot(grant_q);
         end
         if (abort_c) begin
            result_q    <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= onehot(grant_q);
         end
         if (release_c) begin
            last_grant_q <= grant_q;
            served_q     <= served_q + 16'd1;
            rsp_valid_q  <= '0;
            err_q        <= 1'b0;
         end
      end
   end

   // req_ready is the only combinational output: the live grant while idle
   assign bus.req_ready        = (state_q == IDLE && grant_vld_c) ? onehot(grant_idx_c) : '0;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_result       = result_q;
   assign bus.rsp_err          = err_q;
   assign bus.gcd_input_ready  = in_rdy_q;
   assign bus.gcd_a            = a_q;
   assign bus.gcd_b            = b_q;
   assign bus.gcd_result_taken = taken_q;
   assign served_cnt           = served_q;
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Scoreboard bench for gcd_req_arbiter with a behavioural GCD unit on the back end.
module tb_gcd_req_arbiter;
   localparam int unsigned N   = 4;
   localparam int unsigned W   = 16;
   localparam int unsigned TMO = 8;

   typedef struct {
      int          idx;
      logic [15:0] res;
      logic        err;
   } exp_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [15:0] served_cnt;

   gcd_req_arbiter_if #(.N_REQ(N), .W(W)) bus ();

   gcd_req_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bus        (bus),
      .served_cnt (served_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cycle    = 0;
   int          resp_cnt = 0;
   int          resp_cycle, acc_cycle, issue_cycle;
   int          taken_hi;
   bit          auto_take, rsp_seen, ir_seen;
   logic [3:0]  stray_take;
   bit          gcd_busy, gcd_hang;
   int          gcd_cnt;
   logic [15:0] gcd_val, last_ga, last_gb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cycle);
   endtask

   function automatic logic [15:0] gcd_ref(input logic [15:0] a_in, input logic [15:0] b_in);
      logic [15:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // One cycle: GCD unit model and response monitor, all driven at negedge
   task automatic tick();
      exp_t e;
      @(negedge sys_clk);
      cycle++;
      if (bus.gcd_result_taken) begin
         taken_hi++;
         bus.gcd_result_rdy = 1'b0;
      end
      if (bus.gcd_input_ready) ir_seen = 1'b1;
      if (gcd_busy) begin
         if (gcd_cnt == 0 && !gcd_hang) begin
            bus.gcd_result_rdy = 1'b1;
            bus.gcd_result     = gcd_val;
            gcd_busy           = 1'b0;
         end else if (gcd_cnt > 0) begin
            gcd_cnt--;
         end
      end else if (bus.gcd_input_ready && bus.gcd_input_available) begin
         gcd_busy    = 1'b1;
         gcd_cnt     = 2;
         last_ga     = bus.gcd_a;
         last_gb     = bus.gcd_b;
         gcd_val     = gcd_ref(bus.gcd_a, bus.gcd_b);
         issue_cycle = cycle;
      end
      if (|bus.rsp_valid) begin
         if (!rsp_seen) begin
            rsp_seen = 1'b1;
            resp_cnt++;
            resp_cycle = cycle;
            if (sb.size() == 0) begin
               check_eq("sb_unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("rsp_onehot", 32'(bus.rsp_valid), 32'd1 << e.idx);
               check_eq("rsp_result", 32'(bus.rsp_result), 32'(e.res));
               check_eq("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
         end
         bus.rsp_taken = auto_take ? bus.rsp_valid : stray_take;
      end else begin
         rsp_seen      = 1'b0;
         bus.rsp_taken = '0;
      end
   endtask

   task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
      bus.req_a[i*16 +: 16] = a;
      bus.req_b[i*16 +: 16] = b;
   endtask

   task automatic push_exp(input int i, input logic [15:0] res, input logic err);
      exp_t e;
      e.idx = i;
      e.res = res;
      e.err = err;
      sb.push_back(e);
   endtask

   // Raise valid on requester i, wait for its grant, drop valid after the accepting edge
   task automatic request(input int i, input logic [15:0] a, input logic [15:0] b, input bit expect_rsp);
      bit ok;
      ok = 1'b0;
      set_ops(i, a, b);
      if (expect_rsp) push_exp(i, gcd_ref(a, b), 1'b0);
      bus.req_valid[i] = 1'b1;
      #1;
      for (int k = 0; k < 100; k++) begin
         if (bus.req_ready[i]) begin
            ok = 1'b1;
            acc_cycle = cycle;
            break;
         end
         tick();
      end
      check_eq("accept", 32'(ok), 32'd1);
      if (ok) tick();
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int k = 0; k < 300; k++) begin
         if (resp_cnt >= target) break;
         tick();
      end
      check_eq("rsp_wait", 32'(resp_cnt >= target), 32'd1);
   endtask

   initial begin
      int bad;
      int idx;
      logic [15:0] ra, rb;

      sys_rst                 = 1'b1;
      bus.req_valid           = '0;
      bus.req_a               = '0;
      bus.req_b               = '0;
      bus.rsp_taken           = '0;
      bus.gcd_input_available = 1'b1;
      bus.gcd_result_rdy      = 1'b0;
      bus.gcd_result          = '0;
      auto_take  = 1'b1;
      stray_take = '0;
      gcd_busy   = 1'b0;
      gcd_hang   = 1'b0;
      taken_hi   = 0;
      repeat (3) tick();

      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
      check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_eq("rst_gcd_in_rdy", 32'(bus.gcd_input_ready), 32'd0);
      check_eq("rst_gcd_taken", 32'(bus.gcd_result_taken), 32'd0);
      check_eq("rst_served", 32'(served_cnt), 32'd0);
      sys_rst = 1'b0;

      // All requesters valid with bypass operands: grants rotate 0,1,2,3,0,...
      for (int i = 0; i < 4; i++) set_ops(i, 16'(10 + i), 16'd0);
      for (int r = 0; r < 8; r++) push_exp(r % 4, 16'(10 + r % 4), 1'b0);
      bus.req_valid = 4'b1111;
      wait_rsp(8);
      bus.req_valid = '0;
      tick();
      check_eq("rr_served", 32'(served_cnt), 32'd8);

      // Full GCD path through the unit
      taken_hi = 0;
      request(0, 16'd48, 16'd18, 1'b1);
      wait_rsp(9);
      repeat (2) tick();
      check_eq("gcd_a", 32'(last_ga), 32'd48);
      check_eq("gcd_b", 32'(last_gb), 32'd18);
      check_eq("taken_pulse", 32'(taken_hi), 32'd1);

      // Bypass: one-cycle latency, unit never engaged
      ir_seen = 1'b0;
      request(2, 16'd35, 16'd0, 1'b1);
      check_eq("byp_lat_b0", 32'(resp_cycle - acc_cycle), 32'd1);
      request(1, 16'd0, 16'd9, 1'b1);
      check_eq("byp_lat_a0", 32'(resp_cycle - acc_cycle), 32'd1);
      tick();
      check_eq("byp_no_issue", 32'(ir_seen), 32'd0);

      // Random operands through the unit
      for (int r = 0; r < 3; r++) begin
         idx = int'($urandom_range(0, 3));
         ra  = 16'($urandom_range(1, 500));
         rb  = 16'($urandom_range(1, 500));
         request(idx, ra, rb, 1'b1);
         wait_rsp(12 + r);
      end

      // Unit never answers: abort after TMO wait cycles
      gcd_hang = 1'b1;
      push_exp(3, 16'd0, 1'b1);
      request(3, 16'd12, 16'd8, 1'b0);
      wait_rsp(15);
      check_eq("timeout_lat", 32'(resp_cycle - issue_cycle), 32'(TMO + 1));
      gcd_hang = 1'b0;
      gcd_busy = 1'b0;
      tick();

      // Response held: no new grant, stray taken bits ignored
      auto_take  = 1'b0;
      stray_take = 4'b1101;
      request(1, 16'd7, 16'd0, 1'b1);
      set_ops(0, 16'd5, 16'd0);
      push_exp(0, 16'd5, 1'b0);
      bus.req_valid[0] = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.rsp_valid !== 4'b0010 || bus.req_ready !== 4'b0000) bad++;
      end
      check_eq("hold_cycles_bad", 32'(bad), 32'd0);
      check_eq("hold_served", 32'(served_cnt), 32'd15);
      auto_take  = 1'b1;
      stray_take = '0;
      wait_rsp(17);
      bus.req_valid[0] = 1'b0;
      tick();
      check_eq("served_total", 32'(served_cnt), 32'd17);

      // Reset pulsed mid-WAIT aborts without a response
      gcd_hang = 1'b1;
      request(2, 16'd20, 16'd15, 1'b0);
      for (int k = 0; k < 20 && !gcd_busy; k++) tick();
      repeat (2) tick();
      #2;
      sys_rst = 1'b1;
      #1;
      check_eq("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("arst_gcd_in_rdy", 32'(bus.gcd_input_ready), 32'd0);
      check_eq("arst_gcd_a", 32'(bus.gcd_a), 32'd0);
      check_eq("arst_served", 32'(served_cnt), 32'd0);
      gcd_hang = 1'b0;
      gcd_busy = 1'b0;
      repeat (2) tick();
      sys_rst = 1'b0;
      for (int i = 0; i < 4; i++) set_ops(i, 16'(30 + i), 16'd0);
      push_exp(0, 16'd30, 1'b0);
      bus.req_valid = 4'b1111;
      wait_rsp(resp_cnt + 1);
      bus.req_valid = '0;
      repeat (2) tick();
      check_eq("post_rst_served", 32'(served_cnt), 32'd1);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
